// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write side: default sizes,
// the binary-to-Gray helper and the burst-lock state type.
package fifo_pkg;

    localparam int DATASIZE_DEF = 8;
    localparam int ADDRSIZE_DEF = 4;

    // Burst lock state used when ARB_LOCK_EN is defined
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    // Reflected binary Gray code; callers size-cast to their pointer width
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one past the last
// grant, so the most recently served requester has the lowest priority.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o
);

    logic [IDW-1:0] idx;
    logic           found;

    // Walk the requesters in rotated order and grant the first valid one
    always_comb begin
        grant_o     = '0;
        grant_idx_o = last_i;
        found       = 1'b0;
        idx         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_i) + k) % NREQ);
            if (en_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Write-side controller of the async FIFO. Arbitrates the memory write
// port among NREQ requesters round-robin, owns the binary/Gray write
// pointer and computes a registered full flag from the synchronised
// read pointer.
// Optional feature: define ARB_LOCK_EN to keep the grant on one
// requester until it delivers a beat with req_last set.
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int NREQ     = 4
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic [ADDRSIZE:0]        wq2_rptr,
    output logic                     wclken,
    output logic [ADDRSIZE-1:0]      waddr,
    output logic [DATASIZE-1:0]      wdata,
    output logic                     wfull,
    output logic [ADDRSIZE:0]        wptr,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = ADDRSIZE + 1;

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wgray_d;
    logic              wfull_q, wfull_d;
    logic [IDW-1:0]    grantId_q, grantId_d;
    logic [NREQ-1:0]   arbReq;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grantIdx;
    logic              arbEnable;
    logic              accept;

`ifdef ARB_LOCK_EN
    lock_state_t lock_q, lock_d;

    // While locked, only the requester holding the burst may compete
    always_comb begin
        arbReq = req_valid;
        if (lock_q == ST_LOCKED) begin
            arbReq = req_valid & (NREQ'(1) << grantId_q);
        end
    end

    // Lock on a non-final beat, release on the final beat of the burst
    always_comb begin
        lock_d = lock_q;
        if (accept) begin
            lock_d = req_last[grantIdx] ? ST_OPEN : ST_LOCKED;
        end
    end

    // Burst lock state register
    always_ff @(posedge wclk) begin
        if (wrst) begin
            lock_q <= ST_OPEN;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_req_last;

    assign arbReq          = req_valid;
    assign unused_req_last = ^req_last;
`endif

    // No grants while full or in reset, so nothing can be written then
    assign arbEnable = !wfull_q && !wrst;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req_i      (arbReq),
        .last_i     (grantId_q),
        .en_i       (arbEnable),
        .grant_o    (grant),
        .grant_idx_o(grantIdx)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign wclken    = accept;
    assign wdata     = req_data[int'(grantIdx)*DATASIZE +: DATASIZE];
    assign waddr     = wbin_q[ADDRSIZE-1:0];
    assign wptr      = wptr_q;
    assign wfull     = wfull_q;
    assign grant_id  = grantId_q;

    // Next pointer, full test against the read pointer, and fairness update
    always_comb begin
        wbin_d    = wbin_q + {{ADDRSIZE{1'b0}}, accept};
        wgray_d   = PW'(bin2gray(32'(wbin_d)));
        wfull_d   = (wgray_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                  wq2_rptr[ADDRSIZE-2:0]});
        grantId_d = accept ? grantIdx : grantId_q;
    end

    // Pointer, full flag and last-grant registers; reset wins over an accept
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q    <= '0;
            wptr_q    <= '0;
            wfull_q   <= 1'b0;
            grantId_q <= IDW'(NREQ - 1);
        end else begin
            wbin_q    <= wbin_d;
            wptr_q    <= wgray_d;
            wfull_q   <= wfull_d;
            grantId_q <= grantId_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter (default sizes 8/4/4).
// Hand vectors for ordering and reset, plus randomized traffic checked
// against an occupancy/round-robin reference model.
module tb_fifo_write_arbiter;

    localparam int DATASIZE = 8;
    localparam int ADDRSIZE = 4;
    localparam int NREQ     = 4;
    localparam int DEPTH    = 16;
    localparam int PMOD     = 32;

    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [4:0]  wq2_rptr;
    logic        wclken;
    logic [3:0]  waddr;
    logic [7:0]  wdata;
    logic        wfull;
    logic [4:0]  wptr;
    logic [1:0]  grant_id;

    int checks = 0;
    int errors = 0;

    // Reference model: total writes/reads mod 2*DEPTH, last grant, full flag
    int mWcnt;
    int mRcnt;
    int mGid;
    bit mFull;
    int expGrant;
`ifdef ARB_LOCK_EN
    bit mLocked;
`endif

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] expReady;
        logic [1:0] expGid;
        logic [4:0] expWptr;
        logic       expFull;
    } vec_t;

    vec_t vecs[9];

    fifo_write_arbiter #(
        .DATASIZE(DATASIZE),
        .ADDRSIZE(ADDRSIZE),
        .NREQ    (NREQ)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .wq2_rptr (wq2_rptr),
        .wclken   (wclken),
        .waddr    (waddr),
        .wdata    (wdata),
        .wfull    (wfull),
        .wptr     (wptr),
        .grant_id (grant_id)
    );

    always #5 wclk = ~wclk;

    function automatic int gray(input int b);
        return (b ^ (b >> 1)) & (PMOD - 1);
    endfunction

    // Round-robin rule: first valid requester after the last grant
    function int predictGrant(input logic [3:0] v);
        int idx;
        if (mFull) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (mGid + k) % NREQ;
`ifdef ARB_LOCK_EN
            if (mLocked && idx != mGid) continue;
`endif
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task applyStimulus(input logic [3:0] v, input logic [3:0] l, input int rcnt);
        req_valid = v;
        req_last  = l;
        req_data  = $urandom;
        mRcnt     = rcnt % PMOD;
        wq2_rptr  = 5'(gray(mRcnt));
    endtask

    // One cycle against the model; call right after applyStimulus
    task modelCycle(input string tag);
        expGrant = predictGrant(req_valid);
        @(negedge wclk);
        checkOutput({tag, " ready"}, 32'(req_ready),
                    (expGrant >= 0) ? (32'(1) << expGrant) : 32'(0));
        checkOutput({tag, " wclken"}, 32'(wclken), 32'(expGrant >= 0));
        checkOutput({tag, " waddr"}, 32'(waddr), 32'(mWcnt % DEPTH));
        checkOutput({tag, " wptr"}, 32'(wptr), 32'(gray(mWcnt)));
        checkOutput({tag, " wfull"}, 32'(wfull), 32'(mFull));
        checkOutput({tag, " grant_id"}, 32'(grant_id), 32'(mGid));
        if (expGrant >= 0) begin
            checkOutput({tag, " wdata"}, 32'(wdata), 32'(req_data[expGrant*DATASIZE +: DATASIZE]));
        end
        @(posedge wclk);
        if (expGrant >= 0) begin
            mWcnt = (mWcnt + 1) % PMOD;
            mGid  = expGrant;
`ifdef ARB_LOCK_EN
            mLocked = !req_last[expGrant];
`endif
        end
        mFull = ((mWcnt - mRcnt + PMOD) % PMOD) == DEPTH;
        #1;
    endtask

    task doReset();
        wrst = 1'b1;
        applyStimulus(4'b1111, 4'b1111, 0);
        @(negedge wclk);
        checkOutput("reset ready", 32'(req_ready), 32'(0));
        checkOutput("reset wclken", 32'(wclken), 32'(0));
        @(posedge wclk);
        #1;
        wrst      = 1'b0;
        req_valid = 4'b0000;
        mWcnt = 0;
        mRcnt = 0;
        mGid  = NREQ - 1;
        mFull = 1'b0;
`ifdef ARB_LOCK_EN
        mLocked = 1'b0;
`endif
        checkOutput("reset grant_id", 32'(grant_id), 32'(3));
        checkOutput("reset wptr", 32'(wptr), 32'(0));
        checkOutput("reset wfull", 32'(wfull), 32'(0));
        checkOutput("reset waddr", 32'(waddr), 32'(0));
    endtask

    initial begin
        logic [4:0] prevPtr;
        int rc;
        int exp4[4];
        int pct;

        wrst      = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        wq2_rptr  = '0;
        repeat (2) @(posedge wclk);
        #1;
        doReset();

        // Rotation from the last grant, then reset on top of an active request
        vecs[0] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 5'b00001, 1'b0};
        vecs[1] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 5'b00011, 1'b0};
        vecs[2] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 5'b00010, 1'b0};
        vecs[3] = '{1'b0, 4'b1010, 4'b1000, 2'd3, 5'b00110, 1'b0};
        vecs[4] = '{1'b0, 4'b1010, 4'b0010, 2'd1, 5'b00111, 1'b0};
        vecs[5] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 5'b00111, 1'b0};
        vecs[6] = '{1'b1, 4'b1111, 4'b0000, 2'd3, 5'b00000, 1'b0};
        vecs[7] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 5'b00001, 1'b0};
        vecs[8] = '{1'b0, 4'b0011, 4'b0010, 2'd1, 5'b00011, 1'b0};
        for (int i = 0; i < 9; i++) begin
            wrst      = vecs[i].rst;
            req_valid = vecs[i].valid;
            req_last  = 4'b1111;
            req_data  = $urandom;
            wq2_rptr  = '0;
            @(negedge wclk);
            checkOutput($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].expReady));
            @(posedge wclk);
            #1;
            checkOutput($sformatf("vec%0d grant_id", i), 32'(grant_id), 32'(vecs[i].expGid));
            checkOutput($sformatf("vec%0d wptr", i), 32'(wptr), 32'(vecs[i].expWptr));
            checkOutput($sformatf("vec%0d wfull", i), 32'(wfull), 32'(vecs[i].expFull));
        end
        wrst = 1'b0;

        // Fill from empty with all requesters active and the reader stalled
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(4'b1111, 4'b1111, 0);
            checkOutput("fill waddr", 32'(waddr), 32'(i));
            modelCycle("fill");
            checkOutput("fill order", 32'(grant_id), 32'(i % NREQ));
        end
        applyStimulus(4'b1111, 4'b1111, 0);
        #2;
        checkOutput("full flag", 32'(wfull), 32'(1));
        checkOutput("full ready", 32'(req_ready), 32'(0));
        modelCycle("full");

        // Reader frees one slot: full drops, arbitration resumes at req 0
        applyStimulus(4'b1111, 4'b1111, 1);
        modelCycle("drain1");
        applyStimulus(4'b1111, 4'b1111, 1);
        #2;
        checkOutput("resume wfull", 32'(wfull), 32'(0));
        checkOutput("resume wptr", 32'(wptr), 32'(5'b11000));
        checkOutput("resume waddr", 32'(waddr), 32'(0));
        checkOutput("resume ready", 32'(req_ready), 32'(4'b0001));
        modelCycle("resume");
        checkOutput("refull", 32'(wfull), 32'(1));

        // Two requesters, req 0 sends a 3-beat burst
`ifdef ARB_LOCK_EN
        exp4 = '{0, 0, 0, 1};
`else
        exp4 = '{0, 1, 0, 1};
`endif
        doReset();
        for (int b = 0; b < 4; b++) begin
            applyStimulus(4'b0011, (b == 2) ? 4'b0011 : 4'b0010, 0);
            modelCycle("burst");
            checkOutput($sformatf("burst beat%0d", b), 32'(grant_id), 32'(exp4[b]));
        end

        // Reader keeps up: pointer wraps in Gray code and never reports full
        doReset();
        prevPtr = wptr;
        for (int i = 0; i < PMOD + 3; i++) begin
            applyStimulus(4'($urandom_range(1, 15)), 4'($urandom), mWcnt);
            modelCycle("wrap");
            checkOutput("wrap gray step", 32'($countones(wptr ^ prevPtr)), 32'(1));
            checkOutput("wrap no full", 32'(wfull), 32'(0));
            prevPtr = wptr;
        end
        checkOutput("wrap final wptr", 32'(wptr), 32'(gray(3)));

        // Random traffic: slow reader first to hit full, then fast reader
        doReset();
        for (int i = 0; i < 400; i++) begin
            pct = (i < 200) ? 25 : 75;
            rc  = mRcnt;
            if (((mWcnt - mRcnt + PMOD) % PMOD) > 0 && $urandom_range(0, 99) < pct) begin
                rc = mRcnt + 1;
            end
            applyStimulus(4'($urandom), 4'($urandom), rc);
            modelCycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
